// File: rtl/cpci_reprog_engine_pkg.sv
// Shared types and constants for the CPCI Virtex reprogramming engine.
// Covers FSM states, error codes and CPCI_REPROG_* register layout.
package cpci_reprog_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PROG_LOW  = 3'd1,
    ST_WAIT_INIT = 3'd2,
    ST_LOAD      = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_INIT_TO = 2'd1,
    ERR_CRC     = 2'd2,
    ERR_OVFL    = 2'd3
  } err_e;

  localparam logic [7:0] CPCI_REPROG_CTRL_ADDR   = 8'h40;
  localparam logic [7:0] CPCI_REPROG_STATUS_ADDR = 8'h44;
  localparam logic [7:0] CPCI_REPROG_DATA_ADDR   = 8'h48;
  localparam logic [7:0] CPCI_REPROG_COUNT_ADDR  = 8'h4c;

  localparam int CPCI_REPROG_CTRL_RESET_BIT   = 0;
  localparam int CPCI_REPROG_STAT_BUSY_BIT    = 0;
  localparam int CPCI_REPROG_STAT_DONE_BIT    = 1;
  localparam int CPCI_REPROG_STAT_ERROR_BIT   = 2;
  localparam int CPCI_REPROG_STAT_ERRCODE_LSB = 3;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/cpci_reprog_engine_fifo.sv
// Single-clock word FIFO for bitstream buffering.
// Power-of-2 depth, wrap-bit pointers, synchronous flush.
module reprog_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q, wp_d;
  logic [AW:0]  rp_q, rp_d;
  logic         do_push;
  logic         do_pop;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign rdata = mem_q[rp_q[AW-1:0]];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (flush) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (do_push) wp_d = wp_q + 1'b1;
      if (do_pop)  rp_d = rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cpci_reprog_engine.sv
// Virtex SelectMAP reprogramming engine: FIFO-buffered words are
// serialised after a PROG_B pulse and INIT_B handshake.
module cpci_reprog_engine
  import cpci_reprog_engine_pkg::*;
#(
  parameter int SMAP_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int CCLK_DIV        = 2,
  parameter int PROG_LOW_CYCLES = 64,
  parameter int INIT_TIMEOUT    = 65535,
  parameter int BIT_SWAP        = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ctrl_reset,
  input  logic                  wr_valid,
  input  logic [31:0]           wr_data,
  output logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [31:0]           word_count,
  output logic                  prog_b_n,
  input  logic                  init_b,
  input  logic                  done_in,
  output logic                  cclk,
  output logic                  cs_b,
  output logic                  rdwr_b,
  output logic [SMAP_WIDTH-1:0] smap_d
);

  localparam int BEATS = 32 / SMAP_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW    = (CCLK_DIV > 1) ? $clog2(CCLK_DIV) : 1;

  localparam logic [31:0] PLOW_END = 32'(PROG_LOW_CYCLES - 1);
  localparam logic [31:0] TO_END   = 32'(INIT_TIMEOUT - 1);
  localparam logic [DW-1:0] DIV_END  = DW'(CCLK_DIV - 1);
  localparam logic [BW-1:0] BEAT_END = BW'(BEATS - 1);

  state_e          state_q, state_d;
  err_e            err_q, err_d;
  logic [31:0]     tmr_q, tmr_d;
  logic [31:0]     wc_q, wc_d;
  logic [31:0]     shift_q, shift_d;
  logic            done_q, done_d;
  logic            fly_q, fly_d;
  logic            phase_q, phase_d;
  logic [DW-1:0]   div_q, div_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [1:0]      init_sync_q, init_sync_d;
  logic [1:0]      done_sync_q, done_sync_d;

  logic            init_s;
  logic            done_s;
  logic            accept;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [31:0]     fifo_rdata;
  logic            ovfl;

  assign init_sync_d = {init_sync_q[0], init_b};
  assign done_sync_d = {done_sync_q[0], done_in};
  assign init_s      = init_sync_q[1];
  assign done_s      = done_sync_q[1];

  assign accept = (state_q == ST_PROG_LOW) ||
                  (state_q == ST_WAIT_INIT) ||
                  (state_q == ST_LOAD);

  // A write coincident with ctrl_reset is dropped, never an overflow.
  assign fifo_push = wr_valid && accept && !fifo_full && !ctrl_reset;
  assign ovfl      = wr_valid && accept && fifo_full && !ctrl_reset;

  reprog_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .flush (ctrl_reset),
    .push  (fifo_push),
    .wdata (wr_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    tmr_d    = tmr_q;
    wc_d     = wc_q;
    shift_d  = shift_q;
    done_d   = done_q;
    fly_d    = fly_q;
    phase_d  = phase_q;
    div_d    = div_q;
    beat_d   = beat_q;
    fifo_pop = 1'b0;
    if (ctrl_reset) begin
      state_d = ST_PROG_LOW;
      err_d   = ERR_NONE;
      tmr_d   = '0;
      wc_d    = '0;
      shift_d = '0;
      done_d  = 1'b0;
      fly_d   = 1'b0;
      phase_d = 1'b0;
      div_d   = '0;
      beat_d  = '0;
    end else begin
      unique case (state_q)
        ST_PROG_LOW: begin
          if (ovfl) begin
            state_d = ST_ERROR;
            err_d   = ERR_OVFL;
          end else if (tmr_q == PLOW_END) begin
            state_d = ST_WAIT_INIT;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        ST_WAIT_INIT: begin
          if (ovfl) begin
            state_d = ST_ERROR;
            err_d   = ERR_OVFL;
          end else if (init_s) begin
            state_d = ST_LOAD;
          end else if (tmr_q == TO_END) begin
            state_d = ST_ERROR;
            err_d   = ERR_INIT_TO;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        ST_LOAD: begin
          if (!init_s || ovfl) begin
            state_d = ST_ERROR;
            err_d   = !init_s ? ERR_CRC : ERR_OVFL;
            fly_d   = 1'b0;
            phase_d = 1'b0;
            div_d   = '0;
          end else if (fly_q) begin
            if (div_q != DIV_END) begin
              div_d = div_q + 1'b1;
            end else begin
              div_d = '0;
              if (!phase_q) begin
                phase_d = 1'b1;
              end else begin
                phase_d = 1'b0;
                if (beat_q == BEAT_END) begin
                  fly_d = 1'b0;
                  wc_d  = wc_q + 1'b1;
                end else begin
                  beat_d  = beat_q + 1'b1;
                  shift_d = shift_q << SMAP_WIDTH;
                end
              end
            end
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            fly_d    = 1'b1;
            phase_d  = 1'b0;
            div_d    = '0;
            beat_d   = '0;
          end else if (done_s) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        ST_IDLE, ST_DONE, ST_ERROR: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      err_q       <= ERR_NONE;
      tmr_q       <= '0;
      wc_q        <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      fly_q       <= 1'b0;
      phase_q     <= 1'b0;
      div_q       <= '0;
      beat_q      <= '0;
      init_sync_q <= '0;
      done_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      tmr_q       <= tmr_d;
      wc_q        <= wc_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      fly_q       <= fly_d;
      phase_q     <= phase_d;
      div_q       <= div_d;
      beat_q      <= beat_d;
      init_sync_q <= init_sync_d;
      done_sync_q <= done_sync_d;
    end
  end

  logic [SMAP_WIDTH-1:0] slice;
  logic [SMAP_WIDTH-1:0] swapped;

  assign slice = shift_q[31 -: SMAP_WIDTH];

  for (genvar g = 0; g < SMAP_WIDTH / 8; g++) begin : g_byte
    assign swapped[g*8 +: 8] = (BIT_SWAP != 0) ?
                               rev8(slice[g*8 +: 8]) :
                               slice[g*8 +: 8];
  end

  assign wr_ready   = accept && !fifo_full;
  assign busy       = accept;
  assign done       = done_q;
  assign error      = (err_q != ERR_NONE);
  assign err_code   = err_q;
  assign word_count = wc_q;
  assign prog_b_n   = (state_q != ST_PROG_LOW);
  assign rdwr_b     = (state_q != ST_LOAD);
  assign cs_b       = !fly_q;
  assign cclk       = fly_q && phase_q;
  assign smap_d     = fly_q ? swapped : '0;

endmodule
